// File: rtl/csa2_32_pkg.sv
// Shared constants, result type and full-adder cell for the 64-bit carry-select adder.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package csa2_32_pkg;

    localparam int WIDTH = 64;
    localparam int HALF  = WIDTH / 2;

    // 65-bit adder result: carry out of the top bit plus the sum bits.
    typedef struct packed {
        logic             c;
        logic [WIDTH-1:0] s;
    } add_res_t;

    // One full-adder cell, returned as {carry_out, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/csa2_32_rca32.sv
// 32-bit ripple-carry adder built as a chain of full-adder cells.
// Latency: combinational; the carry ripples through all 32 cells.
// Backpressure: none.
module csa2_32_rca32
    import csa2_32_pkg::*;
(
    input  logic [HALF-1:0] a_i,
    input  logic [HALF-1:0] b_i,
    input  logic            cin_i,
    output logic [HALF-1:0] s_o,
    output logic            cout_o
);

    // c[i] is the carry into bit i; c[HALF] leaves the block.
    logic [HALF:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < HALF; i++) begin : g_cell
        assign {c[i+1], s_o[i]} = fa(a_i[i], b_i[i], c[i]);
    end

    assign cout_o = c[HALF];

endmodule

// File: rtl/csa2_32.sv
// 64-bit two-block carry-select adder with carry-in and a registered result.
// Latency: 1 cycle from in_valid to out_valid; one result per cycle.
// Backpressure: none; the result holds while in_valid is low.
module csa2_32
    import csa2_32_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
);

    localparam int HALF = WIDTH / 2;

    logic [HALF-1:0] s_lo;
    logic [HALF-1:0] s_hi0;
    logic [HALF-1:0] s_hi1;
    logic            c32;
    logic            c0;
    logic            c1;

    add_res_t res_d;
    add_res_t res_q;
    logic     out_valid_q;

    // Lower block sees the real carry-in.
    csa2_32_rca32 u_lo (
        .a_i    (a[HALF-1:0]),
        .b_i    (b[HALF-1:0]),
        .cin_i  (c_in),
        .s_o    (s_lo),
        .cout_o (c32)
    );

    // Upper block precomputed assuming no carry from the lower half.
    csa2_32_rca32 u_hi0 (
        .a_i    (a[WIDTH-1:HALF]),
        .b_i    (b[WIDTH-1:HALF]),
        .cin_i  (1'b0),
        .s_o    (s_hi0),
        .cout_o (c0)
    );

    // Upper block precomputed assuming a carry from the lower half.
    csa2_32_rca32 u_hi1 (
        .a_i    (a[WIDTH-1:HALF]),
        .b_i    (b[WIDTH-1:HALF]),
        .cin_i  (1'b1),
        .s_o    (s_hi1),
        .cout_o (c1)
    );

    // Lower-half carry picks the matching upper candidate.
    always_comb begin
        res_d.s = c32 ? {s_hi1, s_lo} : {s_hi0, s_lo};
        res_d.c = c32 ? c1 : c0;
    end

    // Capture on in_valid, otherwise hold; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign sum       = res_q.s;
    assign c_out     = res_q.c;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_csa2_32.sv
// Self-checking bench for csa2_32: golden 65-bit arithmetic model plus directed literals.
// Latency: expects results one cycle after each accepted input.
// Backpressure: none; drives back-to-back vectors.
module tb_csa2_32;
    import csa2_32_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             out_valid;

    int n_total;
    int n_pass;

    // Model state: what the outputs must show after the latest edge.
    logic     mdl_live;
    logic     mdl_vld;
    add_res_t mdl_res;

    csa2_32 #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden reference: plain 65-bit arithmetic.
    function automatic add_res_t rca64_ref(input logic [63:0] x, input logic [63:0] y,
                                           input logic ci);
        logic [64:0] t;
        t = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        return add_res_t'(t);
    endfunction

    // Model update at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            mdl_live <= 1'b1;
            mdl_vld  <= 1'b0;
            mdl_res  <= '0;
        end else begin
            mdl_vld <= in_valid;
            if (in_valid) mdl_res <= rca64_ref(a, b, c_in);
        end
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%017h expected 0x%017h", name, act, exp);
    endtask

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (mdl_live === 1'b1) begin
            check("model_out_valid", {64'd0, out_valid}, {64'd0, mdl_vld});
            check("model_result", {c_out, sum}, mdl_res);
        end
    end

    // Apply one vector for one cycle, then check literal expectations.
    task automatic vec(input string name, input logic [63:0] va, input logic [63:0] vb,
                       input logic vc, input logic [63:0] es, input logic ec);
        a = va; b = vb; c_in = vc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, {64'd0, out_valid}, 65'd1);
        check(name, {c_out, sum}, {ec, es});
        @(posedge clk); #1;
    endtask

    initial begin
        add_res_t last;
        n_total = 0; n_pass = 0;
        mdl_live = 1'b0; mdl_vld = 1'b0; mdl_res = '0;
        rst_n = 1'b0; in_valid = 1'b1;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; c_in = 1'b1;

        // Reset overrides in_valid for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {64'd0, out_valid}, 65'd0);
        check("reset_result", {c_out, sum}, 65'd0);

        // Release with nothing offered: still no result.
        #1 rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_valid", {64'd0, out_valid}, 65'd0);
        check("idle_result", {c_out, sum}, 65'd0);

        vec("small_1_1_1", 64'h1, 64'h1, 1'b1, 64'h3, 1'b0);
        vec("small_f_f_0", 64'hF, 64'hF, 1'b0, 64'h1E, 1'b0);
        vec("cross_half", 64'h0000_0000_FFFF_FFFF, 64'hBA, 1'b1, 64'h0000_0001_0000_00BA, 1'b0);
        vec("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h1, 1'b1);
        vec("compl_cin0", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vec("compl_cin1", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1);
        vec("zero_cin1", 64'h0, 64'h0, 1'b1, 64'h1, 1'b0);
        vec("upper_only", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1);

        // Back-to-back random vectors, checked every cycle by the model process.
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c_in = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        last = rca64_ref(a, b, c_in);

        // Drop in_valid: last result holds, valid falls.
        in_valid = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        @(negedge clk);
        check("stream_last", {c_out, sum}, last);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_valid", {64'd0, out_valid}, 65'd0);
        check("hold_result", {c_out, sum}, last);

        // Reset mid-stream discards the in-flight result.
        @(posedge clk); #1;
        a = 64'h5; b = 64'h6; c_in = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("midreset_valid", {64'd0, out_valid}, 65'd0);
        check("midreset_result", {c_out, sum}, 65'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
